// File: rtl/vram_writer_pkg.sv
// Shared region table, state and mode encodings for the VRAM burst writer.
// Optional fill mode is enabled by defining VRAM_WRITER_FILL_EN.
package vram_writer_pkg;

  localparam int VRAM_MAX_REGIONS = 4;
  localparam int VRAM_REGION_W    = 2;

  // Inclusive word-address ranges: tile, pattern, palette, sprite.
  localparam logic [31:0] VRAM_REGION_BASE [VRAM_MAX_REGIONS] =
    '{32'h0000_0000, 32'h0000_0800, 32'h0000_1800, 32'h0000_1A00};
  localparam logic [31:0] VRAM_REGION_LIMIT [VRAM_MAX_REGIONS] =
    '{32'h0000_07FF, 32'h0000_17FF, 32'h0000_19FF, 32'h0000_1A27};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

  typedef enum logic {
    MODE_ENDPOINTS = 1'b0,
    MODE_FILL      = 1'b1
  } writer_mode_t;

endpackage

// File: rtl/vram_region_walker.sv
// Walks the region table producing the current write address; steps on accept.
// Fill-mode address stepping exists only when VRAM_WRITER_FILL_EN is defined.
module vram_region_walker
  import vram_writer_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int NUM_REGIONS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     advance,
`ifdef VRAM_WRITER_FILL_EN
  input  logic                     fill,
`endif
  output logic [VRAM_REGION_W-1:0] region,
  output logic [ADDR_W-1:0]        addr,
  output logic                     last
);

  localparam int AW1 = ADDR_W + 1;
  localparam logic [VRAM_REGION_W-1:0] LAST_REGION = VRAM_REGION_W'(NUM_REGIONS - 1);

  logic [VRAM_REGION_W-1:0] region_q, region_d, region_nx;
  logic                     phase_q, phase_d;
  logic [AW1-1:0]           addr_q, addr_d;

  function automatic logic [AW1-1:0] base_of(input logic [VRAM_REGION_W-1:0] r);
    return AW1'(VRAM_REGION_BASE[r]);
  endfunction

  function automatic logic [AW1-1:0] limit_of(input logic [VRAM_REGION_W-1:0] r);
    return AW1'(VRAM_REGION_LIMIT[r]);
  endfunction

  assign region_nx = region_q + VRAM_REGION_W'(1);

  // Endpoint walk: phase 0 presents base, phase 1 presents limit.
  always_comb begin
    region_d = region_q;
    phase_d  = phase_q;
    addr_d   = addr_q;
    if (start) begin
      region_d = '0;
      phase_d  = 1'b0;
      addr_d   = base_of('0);
    end else if (advance) begin
      if (phase_q) begin
        region_d = region_nx;
        phase_d  = 1'b0;
        addr_d   = base_of(region_nx);
      end else begin
        phase_d = 1'b1;
        addr_d  = limit_of(region_q);
      end
`ifdef VRAM_WRITER_FILL_EN
      if (fill) begin
        phase_d = 1'b0;
        if (addr_q == limit_of(region_q)) begin
          region_d = region_nx;
          addr_d   = base_of(region_nx);
        end else begin
          region_d = region_q;
          addr_d   = addr_q + AW1'(1);
        end
      end
`endif
    end
  end

  always_comb begin
    last = (region_q == LAST_REGION) && phase_q;
`ifdef VRAM_WRITER_FILL_EN
    if (fill) begin
      last = (region_q == LAST_REGION) && (addr_q == limit_of(region_q));
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      region_q <= '0;
      phase_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      region_q <= region_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
    end
  end

  assign region = region_q;
  assign addr   = addr_q[ADDR_W-1:0];

`ifndef VRAM_WRITER_FILL_EN
  logic unused_addr_msb;
  assign unused_addr_msb = addr_q[ADDR_W];
`endif

endmodule

// File: rtl/vram_burst_writer.sv
// Triggered VRAM write burst generator (endpoint or fill walk, seeded data).
// Fill mode is compiled in only when VRAM_WRITER_FILL_EN is defined.
module vram_burst_writer
  import vram_writer_pkg::*;
#(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 64,
  parameter int NUM_REGIONS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger,
  input  logic                mode,
  input  logic [DATA_W-1:0]   seed,
  output logic [ADDR_W-1:0]   h2f_vram_wraddr,
  output logic                h2f_vram_wren,
  output logic [DATA_W-1:0]   h2f_vram_wrdata,
  output logic [DATA_W/8-1:0] h2f_vram_byteena,
  input  logic                h2f_vram_wrready,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state
);

  // Write port handshake: a write transfers on each rising clk where wren and
  // wrready are both high; while wren is high without wrready, addr/data/byteena hold.

  writer_state_t             state_q, state_d;
  logic                      start, finish, accept;
  logic                      pending_q, wren_q, busy_q, done_q;
  logic [DATA_W/8-1:0]       byteena_q;
  logic [DATA_W-1:0]         data_q;
  logic                      walk_last;
  logic [VRAM_REGION_W-1:0]  unused_region;

  assign accept = wren_q && h2f_vram_wrready;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger || pending_q) begin
          start   = 1'b1;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept && walk_last) begin
          finish  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      wren_q    <= 1'b0;
      byteena_q <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= finish;
      // Any trigger not consumed by a start is remembered once.
      if (start) begin
        pending_q <= 1'b0;
      end else if (trigger) begin
        pending_q <= 1'b1;
      end
      if (start) begin
        wren_q    <= 1'b1;
        byteena_q <= '1;
        busy_q    <= 1'b1;
      end else if (finish) begin
        wren_q    <= 1'b0;
        byteena_q <= '0;
        busy_q    <= 1'b0;
      end
      if (start) begin
        data_q <= seed;
      end else if (accept) begin
        data_q <= data_q + DATA_W'(1);
      end
    end
  end

`ifdef VRAM_WRITER_FILL_EN
  writer_mode_t mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_ENDPOINTS;
    end else if (start) begin
      mode_q <= writer_mode_t'(mode);
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  vram_region_walker #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS)
  ) u_walker (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .advance (accept),
`ifdef VRAM_WRITER_FILL_EN
    .fill    (mode_q == MODE_FILL),
`endif
    .region  (unused_region),
    .addr    (h2f_vram_wraddr),
    .last    (walk_last)
  );

  assign h2f_vram_wren    = wren_q;
  assign h2f_vram_wrdata  = data_q;
  assign h2f_vram_byteena = byteena_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign state            = state_q;

endmodule

// File: tb/tb_vram_burst_writer.sv
// Directed bench for vram_burst_writer: reset, endpoint/fill bursts, stalls,
// pending trigger, data wrap and mid-burst reset.
module tb_vram_burst_writer;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int EW     = ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              trigger;
  logic              mode;
  logic [DATA_W-1:0] seed;
  logic [ADDR_W-1:0] wraddr;
  logic              wren;
  logic [DATA_W-1:0] wrdata;
  logic [7:0]        byteena;
  logic              wrready;
  logic              busy;
  logic              done;
  logic [1:0]        state;

  int vectors     = 0;
  int miscompares = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];
  int            done_q[$];
  int            rise_q[$];
  int            stable_err, be_err;
  logic          busy_first, busy_at_done;

  logic [ADDR_W-1:0] ep_addr [8] = '{13'h0000, 13'h07FF, 13'h0800, 13'h17FF,
                                     13'h1800, 13'h19FF, 13'h1A00, 13'h1A27};
  logic [ADDR_W-1:0] reg_base [4] = '{13'h0000, 13'h0800, 13'h1800, 13'h1A00};
  logic [ADDR_W-1:0] reg_lim  [4] = '{13'h07FF, 13'h17FF, 13'h19FF, 13'h1A27};
  logic [4:0]        ready_pat = 5'b10010;

  vram_burst_writer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGIONS(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .trigger          (trigger),
    .mode             (mode),
    .seed             (seed),
    .h2f_vram_wraddr  (wraddr),
    .h2f_vram_wren    (wren),
    .h2f_vram_wrdata  (wrdata),
    .h2f_vram_byteena (byteena),
    .h2f_vram_wrready (wrready),
    .busy             (busy),
    .done             (done),
    .state            (state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver tasks
  task automatic fire(input logic m, input logic [DATA_W-1:0] s);
    @(negedge clk);
    mode    = m;
    seed    = s;
    trigger = 1'b1;
  endtask

  task automatic run_capture(input int budget, input int n_bursts, input bit stall,
                             input bit extra_trig, input logic [DATA_W-1:0] new_seed,
                             output bit timed_out);
    int cyc;
    int seen;
    bit held;
    bit prev_wren;
    logic [ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0] hold_data;
    cyc = 0; seen = 0; held = 0; prev_wren = 0;
    hold_addr = '0; hold_data = '0;
    got_q.delete(); done_q.delete(); rise_q.delete();
    stable_err = 0; be_err = 0; busy_first = 1'b0; busy_at_done = 1'b1;
    timed_out = 1'b1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      trigger = extra_trig && (cyc == 2 || cyc == 4 || cyc == 6);
      if (extra_trig && cyc == 2) seed = new_seed;
      wrready = stall ? ready_pat[cyc % 5] : 1'b1;
      #1;
      if (cyc == 1) busy_first = busy;
      if (held && (!wren || wraddr !== hold_addr || wrdata !== hold_data)) stable_err++;
      if ((wren && byteena !== 8'hFF) || (!wren && byteena !== 8'h00)) be_err++;
      if (wren && !prev_wren) rise_q.push_back(cyc);
      prev_wren = wren;
      if (wren && wrready) got_q.push_back({wraddr, wrdata});
      held      = wren && !wrready;
      hold_addr = wraddr;
      hold_data = wrdata;
      if (done) begin
        done_q.push_back(cyc);
        busy_at_done = busy;
        seen++;
        if (seen == n_bursts) begin
          timed_out = 1'b0;
          break;
        end
      end
    end
    trigger = 1'b0;
    wrready = 1'b1;
  endtask

  task automatic push_endpoints(input logic [DATA_W-1:0] s);
    for (int i = 0; i < 8; i++) exp_q.push_back({ep_addr[i], s + 64'(i)});
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; trigger = 1'b0; mode = 1'b0; seed = '0; wrready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (wraddr !== '0) begin miscompares++; $display("FAIL reset_wraddr got %h want 0", wraddr); end
    vectors++; if (wren !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %b want 0", wren); end
    vectors++; if (wrdata !== '0) begin miscompares++; $display("FAIL reset_wrdata got %h want 0", wrdata); end
    vectors++; if (byteena !== 8'h00) begin miscompares++; $display("FAIL reset_byteena got %h want 00", byteena); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_endpoint();
    bit to;
    exp_q.delete();
    push_endpoints(64'd12345);
    fire(1'b0, 64'd12345);
    run_capture(40, 1, 1'b0, 1'b0, '0, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL ep_timeout got timeout want done"); end
    vectors++; if (busy_first !== 1'b1) begin miscompares++; $display("FAIL ep_busy_start got %b want 1", busy_first); end
    vectors++; if ((rise_q.size() > 0 ? rise_q[0] : -1) != 1) begin miscompares++; $display("FAIL ep_start_latency got %0d want 1", rise_q.size() > 0 ? rise_q[0] : -1); end
    vectors++; if (got_q.size() != 8) begin miscompares++; $display("FAIL ep_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [EW-1:0] e;
      logic [EW-1:0] g;
      e = exp_q.pop_front();
      g = (i < got_q.size()) ? got_q[i] : '1;
      vectors++; if (g !== e) begin miscompares++; $display("FAIL ep_write%0d got %h want %h", i, g, e); end
    end
    vectors++; if ((done_q.size() > 0 ? done_q[0] : -1) != 9) begin miscompares++; $display("FAIL ep_done_cycle got %0d want 9", done_q.size() > 0 ? done_q[0] : -1); end
    vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL ep_busy_at_done got %b want 0", busy_at_done); end
    vectors++; if (be_err != 0) begin miscompares++; $display("FAIL ep_byteena got %0d bad cycles want 0", be_err); end
    @(negedge clk); #1;
    vectors++; if (state !== 2'd0 || wren !== 1'b0) begin miscompares++; $display("FAIL ep_idle_after got state %0d wren %b want 0 0", state, wren); end
  endtask

  task automatic test_fill();
    bit to;
    int bad_idx;
    int want_n;
    logic [DATA_W-1:0] n;
    exp_q.delete();
`ifdef VRAM_WRITER_FILL_EN
    n = '0;
    for (int r = 0; r < 4; r++) begin
      for (int a = int'(reg_base[r]); a <= int'(reg_lim[r]); a++) begin
        exp_q.push_back({13'(a), n});
        n = n + 64'd1;
      end
    end
    want_n = 6696;
`else
    n = '0;
    push_endpoints(64'd0);
    want_n = 8;
`endif
    fire(1'b1, 64'd0);
    run_capture(7000, 1, 1'b0, 1'b0, '0, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL fill_timeout got timeout want done"); end
    vectors++; if (got_q.size() != want_n) begin miscompares++; $display("FAIL fill_count got %0d want %0d", got_q.size(), want_n); end
    bad_idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad_idx = i; break; end
    end
    vectors++; if (bad_idx != -1) begin miscompares++; $display("FAIL fill_sequence got first bad write %0d want none", bad_idx); end
`ifdef VRAM_WRITER_FILL_EN
    vectors++; if (got_q.size() == 0 || got_q[got_q.size()-1] !== {13'h1A27, 64'd6695}) begin
      miscompares++; $display("FAIL fill_last got %h want %h", got_q.size() == 0 ? '0 : got_q[got_q.size()-1], {13'h1A27, 64'd6695}); end
`endif
    @(negedge clk);
  endtask

  task automatic test_stall();
    bit to;
    int bad_idx;
    exp_q.delete();
    push_endpoints(64'd100);
    fire(1'b0, 64'd100);
    run_capture(100, 1, 1'b1, 1'b0, '0, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL stall_timeout got timeout want done"); end
    vectors++; if (got_q.size() != 8) begin miscompares++; $display("FAIL stall_count got %0d want 8", got_q.size()); end
    bad_idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad_idx = i; break; end
    end
    vectors++; if (bad_idx != -1) begin miscompares++; $display("FAIL stall_sequence got first bad write %0d want none", bad_idx); end
    vectors++; if (stable_err != 0) begin miscompares++; $display("FAIL stall_hold got %0d changes while stalled want 0", stable_err); end
    vectors++; if (be_err != 0) begin miscompares++; $display("FAIL stall_byteena got %0d bad cycles want 0", be_err); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit to;
    int bad_idx;
    exp_q.delete();
    push_endpoints(64'd500);
    push_endpoints(64'd9000);
    fire(1'b0, 64'd500);
    run_capture(60, 2, 1'b0, 1'b1, 64'd9000, to);
    vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL b2b_timeout got timeout want two dones"); end
    vectors++; if (got_q.size() != 16) begin miscompares++; $display("FAIL b2b_count got %0d want 16", got_q.size()); end
    bad_idx = -1;
    for (int i = 0; i < 16; i++) begin
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin bad_idx = i; break; end
    end
    vectors++; if (bad_idx != -1) begin miscompares++; $display("FAIL b2b_sequence got first bad write %0d want none", bad_idx); end
    vectors++; if ((rise_q.size() > 1 ? rise_q[1] : -1) != 11) begin miscompares++; $display("FAIL b2b_restart_cycle got %0d want 11", rise_q.size() > 1 ? rise_q[1] : -1); end
    vectors++; if ((done_q.size() > 1 ? done_q[1] : -1) != 19) begin miscompares++; $display("FAIL b2b_done2_cycle got %0d want 19", done_q.size() > 1 ? done_q[1] : -1); end
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (wren !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_no_third got wren %b busy %b want 0 0", wren, busy); end
  endtask

  task automatic test_wrap();
    bit to;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] want [4];
    want[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    want[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    want[2] = 64'h0;
    want[3] = 64'h1;
    fire(1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_capture(40, 1, 1'b0, 1'b0, '0, to);
    vectors++; if (to !== 1'b0 || got_q.size() != 8) begin miscompares++; $display("FAIL wrap_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      d = (i < got_q.size()) ? got_q[i][DATA_W-1:0] : 64'h5555;
      vectors++; if (d !== want[i]) begin miscompares++; $display("FAIL wrap_data%0d got %h want %h", i, d, want[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit to;
    fire(1'b1, 64'd0);
    repeat (5) @(negedge clk);
    trigger = 1'b0;
    rst = 1'b1;
    @(negedge clk); #1;
    vectors++; if (wren !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rstmid_ctrl got wren %b busy %b done %b want 0 0 0", wren, busy, done); end
    vectors++; if (wraddr !== '0 || wrdata !== '0 || byteena !== 8'h00) begin miscompares++; $display("FAIL rstmid_data got %h %h %h want 0 0 0", wraddr, wrdata, byteena); end
    vectors++; if (state !== 2'd0) begin miscompares++; $display("FAIL rstmid_state got %0d want 0", state); end
    rst = 1'b0;
    @(negedge clk); #1;
    vectors++; if (wren !== 1'b0) begin miscompares++; $display("FAIL rstmid_no_pending got wren %b want 0", wren); end
    fire(1'b0, 64'd3);
    run_capture(40, 1, 1'b0, 1'b0, '0, to);
    vectors++; if (to !== 1'b0 || got_q.size() != 8) begin miscompares++; $display("FAIL rstmid_restart_count got %0d want 8", got_q.size()); end
    vectors++; if (got_q.size() == 0 || got_q[0] !== {13'h0000, 64'd3}) begin miscompares++; $display("FAIL rstmid_first got %h want %h", got_q.size() == 0 ? '0 : got_q[0], {13'h0000, 64'd3}); end
  endtask

  initial begin
    test_reset();
    test_endpoint();
    test_fill();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
